fir_tap_sequencer: RTL and testbench

//   Time-multiplexed FIR controller: shares one 8x8 multiplier-accumulator across TAPS taps.

---
 rtl/fir_ctrl_pkg.sv | 32 +++
 rtl/fir_mac.sv | 41 ++++
 rtl/fir_tap_sequencer.sv | 171 +++++++++++++++++
 tb/tb_fir_tap_sequencer.sv | 304 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fir_ctrl_pkg.sv
// Shared types, default widths and arithmetic helpers for the FIR tap sequencer.
//   state_t    : sequencer FSM states
//   *_DEF      : default parameter values
//   acc_w()    : accumulator width needed to sum TAPS full-width products
//   saturate() : clamp an unsigned value to the largest y_w-bit number
package fir_ctrl_pkg;

  localparam int unsigned TAPS_DEF = 4;
  localparam int unsigned X_W_DEF  = 8;
  localparam int unsigned C_W_DEF  = 8;
  localparam int unsigned Y_W_DEF  = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MAC  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Product width plus enough guard bits that TAPS products can never wrap.
  function automatic int unsigned acc_w(input int unsigned x_w, input int unsigned c_w,
                                        input int unsigned taps);
    return x_w + c_w + $clog2(taps);
  endfunction

  // Unsigned clamp; callers keep both the value and y_w below 32 bits.
  function automatic logic [31:0] saturate(input logic [31:0] v, input int unsigned y_w);
    logic [31:0] lim;
    lim = (32'd1 << y_w) - 32'd1;
    return (v > lim) ? lim : v;
  endfunction

endpackage

// File: rtl/fir_mac.sv
// Single shared multiply-accumulate unit.
//   clk, rst : clock and synchronous active-high reset
//   clr      : zero the accumulator (wins over en)
//   en       : add x*c into the accumulator this edge
//   x, c     : unsigned operands
//   acc      : registered accumulator value
module fir_mac #(
  parameter int unsigned X_W   = 8,
  parameter int unsigned C_W   = 8,
  parameter int unsigned ACC_W = 18
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             en,
  input  logic [X_W-1:0]   x,
  input  logic [C_W-1:0]   c,
  output logic [ACC_W-1:0] acc
);

  localparam int unsigned P_W = X_W + C_W;

  logic [P_W-1:0] prod;

  // Full-width unsigned product; never truncated.
  always_comb begin
    prod = P_W'(x) * P_W'(c);
  end

  // Accumulator is wide enough for all taps, so no wrap or clamp here.
  always_ff @(posedge clk) begin
    if (rst) begin
      acc <= '0;
    end else if (clr) begin
      acc <= '0;
    end else if (en) begin
      acc <= acc + ACC_W'(prod);
    end
  end

endmodule

// File: rtl/fir_tap_sequencer.sv
// Time-multiplexed FIR controller: one MAC shared across TAPS taps.
//   clk, rst           : clock and synchronous active-high reset
//   in_valid/in_ready  : sample handshake; ready only while idle
//   in_data            : unsigned input sample
//   coef_we/addr/data  : host coefficient write port
//   coef_err           : one-cycle pulse when a coefficient write is dropped
//   out_valid/out_data : one-cycle result strobe and saturated result (held)
//   busy               : high while a sample is being filtered
module fir_tap_sequencer
  import fir_ctrl_pkg::*;
#(
  parameter int unsigned TAPS = TAPS_DEF,
  parameter int unsigned X_W  = X_W_DEF,
  parameter int unsigned C_W  = C_W_DEF,
  parameter int unsigned Y_W  = Y_W_DEF
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [X_W-1:0] in_data,
  input  logic           coef_we,
  input  logic [3:0]     coef_addr,
  input  logic [C_W-1:0] coef_data,
  output logic           coef_err,
  output logic           out_valid,
  output logic [Y_W-1:0] out_data,
  output logic           busy
);

  localparam int unsigned ACC_W = acc_w(X_W, C_W, TAPS);
  localparam int unsigned K_W   = $clog2(TAPS);

  state_t             state;
  state_t             state_next;
  logic [K_W-1:0]     k;
  logic [X_W-1:0]     x_line [TAPS];
  logic [C_W-1:0]     coef   [TAPS];
  logic               accept;
  logic               mac_en;
  logic               coef_take;
  logic               coef_drop;
  logic [X_W-1:0]     x_sel;
  logic [C_W-1:0]     c_sel;
  logic [ACC_W-1:0]   acc;

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next state and per-cycle control strobes.
  always_comb begin
    state_next = state;
    accept     = 1'b0;
    mac_en     = 1'b0;
    coef_take  = 1'b0;
    coef_drop  = 1'b0;
    case (state)
      IDLE: begin
        if (in_valid) begin
          accept     = 1'b1;
          state_next = MAC;
        end
      end
      MAC: begin
        mac_en = 1'b1;
        if (k == K_W'(TAPS - 1)) begin
          state_next = DONE;
        end
      end
      DONE: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
    // Extra bit so a 16-tap build still compares correctly.
    if (coef_we) begin
      if ((state == IDLE) && ({1'b0, coef_addr} < 5'(TAPS))) begin
        coef_take = 1'b1;
      end else begin
        coef_drop = 1'b1;
      end
    end
  end

  // Sample delay line; newest sample lands in tap 0.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < TAPS; i++) begin
        x_line[i] <= '0;
      end
    end else if (accept) begin
      x_line[0] <= in_data;
      for (int unsigned i = 1; i < TAPS; i++) begin
        x_line[i] <= x_line[i-1];
      end
    end
  end

  // Coefficient bank; a write in the accept cycle lands before the first MAC.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < TAPS; i++) begin
        coef[i] <= '0;
      end
    end else if (coef_take) begin
      for (int unsigned i = 0; i < TAPS; i++) begin
        if (coef_addr == 4'(i)) begin
          coef[i] <= coef_data;
        end
      end
    end
  end

  // Tap counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      k <= '0;
    end else if (accept) begin
      k <= '0;
    end else if (mac_en) begin
      k <= k + K_W'(1);
    end
  end

  always_comb begin
    x_sel = x_line[k];
    c_sel = coef[k];
  end

  fir_mac #(
    .X_W   (X_W),
    .C_W   (C_W),
    .ACC_W (ACC_W)
  ) u_mac (
    .clk (clk),
    .rst (rst),
    .clr (accept),
    .en  (mac_en),
    .x   (x_sel),
    .c   (c_sel),
    .acc (acc)
  );

  // Registered outputs; handshake flags follow the state being entered.
  always_ff @(posedge clk) begin
    if (rst) begin
      in_ready  <= 1'b1;
      busy      <= 1'b0;
      out_valid <= 1'b0;
      coef_err  <= 1'b0;
      out_data  <= '0;
    end else begin
      in_ready  <= (state_next == IDLE);
      busy      <= (state_next != IDLE);
      out_valid <= (state == DONE);
      coef_err  <= coef_drop;
      if (state == DONE) begin
        out_data <= Y_W'(saturate(32'(acc), Y_W));
      end
    end
  end

endmodule

// File: tb/tb_fir_tap_sequencer.sv
// Scoreboard bench for fir_tap_sequencer (TAPS=4): a reference model pushes
// expected results on each accepted sample; a monitor pops them on out_valid.
module tb_fir_tap_sequencer;

  localparam int TAPS = 4;
  localparam int YMAX = 65535;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  in_data;
  logic        coef_we;
  logic [3:0]  coef_addr;
  logic [7:0]  coef_data;
  logic        coef_err;
  logic        out_valid;
  logic [15:0] out_data;
  logic        busy;

  fir_tap_sequencer #(
    .TAPS (TAPS),
    .X_W  (8),
    .C_W  (8),
    .Y_W  (16)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .coef_we   (coef_we),
    .coef_addr (coef_addr),
    .coef_data (coef_data),
    .coef_err  (coef_err),
    .out_valid (out_valid),
    .out_data  (out_data),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int y;
    int cyc;
  } exp_t;

  exp_t sb[$];

  // Reference model state
  int m_hist[TAPS];
  int m_coef[TAPS];
  int busy_left = 0;
  int cyc       = 0;
  int rst_gen   = 0;
  int acc_cnt   = 0;
  bit exp_err   = 1'b0;
  bit exp_ready = 1'b1;
  bit exp_busy  = 1'b0;
  bit started   = 1'b0;

  // Monitor state
  int checks   = 0;
  int errors   = 0;
  int exp_out  = 0;
  int seen_gen = 0;

  // Reference model: a sample is accepted whenever the filter is idle; it then
  // stays busy for TAPS MAC cycles plus one output cycle.
  initial begin
    forever begin
      @(posedge clk);
      cyc++;
      if (rst) begin
        for (int i = 0; i < TAPS; i++) begin
          m_hist[i] = 0;
          m_coef[i] = 0;
        end
        busy_left = 0;
        exp_err   = 1'b0;
        exp_ready = 1'b1;
        exp_busy  = 1'b0;
        rst_gen++;
        started   = 1'b1;
      end else begin
        bit idle;
        idle    = (busy_left == 0);
        exp_err = 1'b0;
        if (coef_we) begin
          if (idle && (int'(coef_addr) < TAPS)) m_coef[int'(coef_addr)] = int'(coef_data);
          else exp_err = 1'b1;
        end
        if (idle && in_valid) begin
          int sum;
          for (int i = TAPS - 1; i > 0; i--) m_hist[i] = m_hist[i-1];
          m_hist[0] = int'(in_data);
          sum = 0;
          for (int i = 0; i < TAPS; i++) sum += m_hist[i] * m_coef[i];
          if (sum > YMAX) sum = YMAX;
          sb.push_back('{sum, cyc});
          busy_left = TAPS + 1;
          acc_cnt++;
        end else if (busy_left > 0) begin
          busy_left--;
        end
        exp_ready = (busy_left == 0);
        exp_busy  = (busy_left != 0);
      end
    end
  end

  task automatic chk(input string name, input int act, input int expv);
    checks++;
    if (act != expv) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %0d expected %0d", name, cyc, act, expv);
    end
  endtask

  // Monitor: compares handshake flags every cycle and results on out_valid.
  initial begin
    forever begin
      @(negedge clk);
      if (started) begin
        if (rst_gen != seen_gen) begin
          seen_gen = rst_gen;
          sb.delete();
          exp_out = 0;
        end
        chk("in_ready", int'(in_ready), int'(exp_ready));
        chk("busy", int'(busy), int'(exp_busy));
        chk("coef_err", int'(coef_err), int'(exp_err));
        if (out_valid) begin
          if (sb.size() == 0) begin
            chk("out_valid_unexpected", int'(out_valid), 0);
          end else begin
            exp_t e;
            e = sb.pop_front();
            chk("out_data", int'(out_data), e.y);
            chk("latency", cyc - e.cyc, TAPS + 1);
            exp_out = e.y;
          end
        end else begin
          chk("out_data_hold", int'(out_data), exp_out);
          if (sb.size() > 0 && (cyc - sb[0].cyc) > TAPS + 1) begin
            chk("out_valid_missing", int'(out_valid), 1);
            void'(sb.pop_front());
          end
        end
      end
    end
  end

  task automatic wait_idle();
    int n;
    n = 0;
    while (!exp_ready) begin
      @(negedge clk);
      n++;
      if (n > 100) begin
        $display("FAIL wait_idle: still busy after %0d cycles", n);
        $fatal(1, "wait_idle timeout");
      end
    end
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sb.size() > 0 || !exp_ready) begin
      @(negedge clk);
      n++;
      if (n > 200) begin
        $display("FAIL drain: %0d results outstanding after %0d cycles", sb.size(), n);
        $fatal(1, "drain timeout");
      end
    end
    @(negedge clk);
  endtask

  task automatic apply_reset(input int n);
    rst = 1'b1;
    repeat (n) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic wcoef(input int a, input int d);
    wait_idle();
    coef_we   = 1'b1;
    coef_addr = 4'(a);
    coef_data = 8'(d);
    @(negedge clk);
    coef_we   = 1'b0;
  endtask

  task automatic send(input int x);
    wait_idle();
    in_valid = 1'b1;
    in_data  = 8'(x);
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  initial begin
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_data   = '0;
    coef_we   = 1'b0;
    coef_addr = '0;
    coef_data = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // All-zero coefficients.
    send(100);
    drain();

    // Ramp coefficients on a fresh delay line.
    apply_reset(1);
    for (int i = 0; i < TAPS; i++) wcoef(i, i + 1);
    send(10); send(20); send(30); send(40);
    drain();

    // Saturation.
    apply_reset(1);
    for (int i = 0; i < TAPS; i++) wcoef(i, 255);
    repeat (4) send(255);
    drain();

    // Dropped writes: one during MAC, one out of range.
    send(50);
    coef_we   = 1'b1;
    coef_addr = 4'd0;
    coef_data = 8'd99;
    @(negedge clk);
    coef_we   = 1'b0;
    drain();
    wcoef(7, 123);
    send(60);
    drain();

    // Reset during the second MAC cycle aborts the result.
    apply_reset(1);
    for (int i = 0; i < TAPS; i++) wcoef(i, i + 1);
    send(77);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    wcoef(0, 1);
    send(5);
    drain();

    // in_valid held high across four back-to-back samples.
    apply_reset(1);
    for (int i = 0; i < TAPS; i++) wcoef(i, int'($urandom_range(0, 255)));
    wait_idle();
    begin
      int base;
      int last;
      int n;
      base = acc_cnt;
      last = acc_cnt;
      n    = 0;
      in_valid = 1'b1;
      in_data  = 8'($urandom);
      while (acc_cnt - base < 4) begin
        @(negedge clk);
        n++;
        if (acc_cnt != last) begin
          last    = acc_cnt;
          in_data = 8'($urandom);
        end
        if (n > 100) begin
          $display("FAIL held_valid: only %0d accepts in %0d cycles", acc_cnt - base, n);
          $fatal(1, "held_valid timeout");
        end
      end
      in_valid = 1'b0;
    end
    drain();

    // Random traffic: samples, coefficient writes and occasional resets.
    repeat (1500) begin
      rst       = ($urandom_range(0, 199) == 0);
      in_valid  = 1'($urandom_range(0, 1));
      in_data   = 8'($urandom);
      coef_we   = ($urandom_range(0, 3) == 0);
      coef_addr = 4'($urandom_range(0, 7));
      coef_data = 8'($urandom);
      @(negedge clk);
    end
    rst      = 1'b0;
    in_valid = 1'b0;
    coef_we  = 1'b0;
    drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
